// File: rtl/ramb4_fifo_pkg.sv
// Shared geometry and occupancy-state definitions for the RAMB4-backed FIFO controller.
package ramb4_fifo_pkg;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 9;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } occ_state_e;
endpackage

// File: rtl/ramb4_fifo_ptr.sv
// Pointer, occupancy count and occupancy FSM for the FIFO controller.
module ramb4_fifo_ptr
  import ramb4_fifo_pkg::*;
#(
  parameter int unsigned AF_THRESH = 240,
  parameter int unsigned AE_THRESH = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_req_i,
  input  logic          rd_req_i,
  output logic          wr_acc_o,
  output logic          rd_acc_o,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          afull_o,
  output logic          aempty_o
);
  occ_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          afull_q, aempty_q;

  assign full_o   = (state_q == S_FULL);
  assign empty_o  = (state_q == S_EMPTY);
  // Acceptance uses only registered flags, so a same-cycle pop never frees a slot for a push.
  assign wr_acc_o = wr_req_i & ~full_o & ~rst_i;
  assign rd_acc_o = rd_req_i & ~empty_o & ~rst_i;
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign afull_o  = afull_q;
  assign aempty_o = aempty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (wr_acc_o) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc_o) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc_o && !rd_acc_o) count_d = count_q + 1'b1;
    else if (rd_acc_o && !wr_acc_o) count_d = count_q - 1'b1;
    unique case (state_q)
      S_EMPTY: if (wr_acc_o) state_d = S_PART;
      S_PART: begin
        if (rd_acc_o && !wr_acc_o && count_q == CW'(1))
          state_d = S_EMPTY;
        else if (wr_acc_o && !rd_acc_o && count_q == CW'(DEPTH - 1))
          state_d = S_FULL;
      end
      S_FULL:  if (rd_acc_o) state_d = S_PART;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= (count_d >= CW'(AF_THRESH));
      aempty_q <= (count_d <= CW'(AE_THRESH));
    end
  end
endmodule

// File: rtl/ramb4_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAMB4 (port A write, port B read).
module ramb4_fifo_ctrl
  import ramb4_fifo_pkg::*;
#(
  parameter int unsigned AF_THRESH = 240,
  parameter int unsigned AE_THRESH = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic [DW-1:0] DIN,
  input  logic          RD_EN,
  output logic [DW-1:0] DOUT,
  output logic          RD_VALID,
  output logic          FULL,
  output logic          EMPTY,
  output logic          AFULL,
  output logic          AEMPTY,
  output logic [CW-1:0] COUNT,
  output logic          OVERFLOW,
  output logic          UNDERFLOW,
  output logic          ENA,
  output logic          WEA,
  output logic [AW-1:0] ADDRA,
  output logic [DW-1:0] DIA,
  output logic          ENB,
  output logic          RSTB,
  output logic [AW-1:0] ADDRB,
  output logic          WEB,
  output logic [DW-1:0] DIB,
  input  logic [DW-1:0] DOB
);
  logic wr_acc, rd_acc;
  logic rd_valid_q, ovf_q, unf_q;

  ramb4_fifo_ptr #(
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ptr (
    .clk_i    (CLK),
    .rst_i    (RST),
    .wr_req_i (WR_EN),
    .rd_req_i (RD_EN),
    .wr_acc_o (wr_acc),
    .rd_acc_o (rd_acc),
    .wr_ptr_o (ADDRA),
    .rd_ptr_o (ADDRB),
    .count_o  (COUNT),
    .full_o   (FULL),
    .empty_o  (EMPTY),
    .afull_o  (AFULL),
    .aempty_o (AEMPTY)
  );

  assign ENA  = wr_acc;
  assign WEA  = wr_acc;
  assign DIA  = DIN;
  assign ENB  = rd_acc;
  assign RSTB = RST;
  assign WEB  = 1'b0;
  assign DIB  = '0;
  assign DOUT = DOB;
  // A read issued just before reset must not surface while reset is being applied.
  assign RD_VALID  = rd_valid_q & ~RST;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      ovf_q      <= WR_EN & FULL;
      unf_q      <= RD_EN & EMPTY;
    end
  end

  a_no_addr_collision: assert property (@(posedge CLK) disable iff (RST)
    !(ENA && ENB && (ADDRA == ADDRB)));
endmodule

// File: tb/tb_ramb4_fifo_ctrl.sv
// Randomized scoreboard bench for ramb4_fifo_ctrl with a behavioural RAMB4 model.
module tb_ramb4_fifo_ctrl;
  logic        CLK, RST, WR_EN, RD_EN;
  logic [15:0] DIN, DOUT, DIA, DIB, DOB;
  logic        RD_VALID, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
  logic [8:0]  COUNT;
  logic        ENA, WEA, ENB, RSTB, WEB;
  logic [7:0]  ADDRA, ADDRB;

  ramb4_fifo_ctrl #(.AF_THRESH(240), .AE_THRESH(16)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .RD_EN(RD_EN), .DOUT(DOUT),
    .RD_VALID(RD_VALID), .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .AEMPTY(AEMPTY),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .ENA(ENA), .WEA(WEA),
    .ADDRA(ADDRA), .DIA(DIA), .ENB(ENB), .RSTB(RSTB), .ADDRB(ADDRB), .WEB(WEB),
    .DIB(DIB), .DOB(DOB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] mem [256];
  always @(posedge CLK) begin
    if (RSTB) DOB <= 16'h0;
    else if (ENB) DOB <= mem[ADDRB];
    if (ENA && WEA) mem[ADDRA] <= DIA;
  end

  int total = 0;
  int bad   = 0;

  logic [15:0] q[$];
  int          m_wptr = 0, m_rptr = 0;
  logic        e_wacc, e_racc, e_rdv, e_ovf, e_unf;
  logic [7:0]  e_addra, e_addrb;
  logic [15:0] e_dout;
  logic        o_ena, o_wea, o_enb, o_rstb, o_rdv;
  logic [7:0]  o_addra, o_addrb;
  logic [15:0] o_dia;

  task automatic tick(input logic wr, input logic [15:0] d, input logic rd, input logic rst);
    logic full_m, empty_m;
    WR_EN = wr; DIN = d; RD_EN = rd; RST = rst;
    @(negedge CLK);
    o_ena = ENA; o_wea = WEA; o_addra = ADDRA; o_dia = DIA;
    o_enb = ENB; o_addrb = ADDRB; o_rstb = RSTB; o_rdv = RD_VALID;
    full_m  = (q.size() == 256);
    empty_m = (q.size() == 0);
    e_wacc  = wr && !full_m && !rst;
    e_racc  = rd && !empty_m && !rst;
    e_addra = 8'(m_wptr);
    e_addrb = 8'(m_rptr);
    @(posedge CLK);
    if (rst) begin
      q.delete(); m_wptr = 0; m_rptr = 0;
      e_rdv = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
    end else begin
      e_ovf = wr && full_m;
      e_unf = rd && empty_m;
      e_rdv = e_racc;
      if (e_racc) begin e_dout = q.pop_front(); m_rptr = (m_rptr + 1) % 256; end
      if (e_wacc) begin q.push_back(d); m_wptr = (m_wptr + 1) % 256; end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 16'hbeef, 1'b1, 1'b1);
    tick(1'b1, 16'hbeef, 1'b1, 1'b1);
    total++; if (o_ena !== 1'b0 || o_enb !== 1'b0) begin bad++; $display("FAIL rst_en ena=%b enb=%b exp 0 0", o_ena, o_enb); end
    total++; if (o_rstb !== 1'b1) begin bad++; $display("FAIL rst_rstb got=%b exp=1", o_rstb); end
    total++; if (WEB !== 1'b0 || DIB !== 16'h0) begin bad++; $display("FAIL tie_b web=%b dib=%0h exp 0 0", WEB, DIB); end
    total++; if (COUNT !== 9'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", COUNT); end
    total++; if ({EMPTY, AEMPTY, FULL, AFULL} !== 4'b1100) begin bad++; $display("FAIL rst_flags got=%b exp=1100", {EMPTY, AEMPTY, FULL, AFULL}); end
    total++; if ({RD_VALID, OVERFLOW, UNDERFLOW} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {RD_VALID, OVERFLOW, UNDERFLOW}); end
    total++; if (DOUT !== 16'h0) begin bad++; $display("FAIL rst_dout got=%0h exp=0", DOUT); end
  endtask

  task automatic test_underflow();
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    total++; if (o_enb !== 1'b0) begin bad++; $display("FAIL unf_enb got=%b exp=0", o_enb); end
    total++; if (UNDERFLOW !== 1'b1 || RD_VALID !== 1'b0) begin bad++; $display("FAIL unf_pulse unf=%b rdv=%b exp 1 0", UNDERFLOW, RD_VALID); end
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    total++; if (UNDERFLOW !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b exp=0", UNDERFLOW); end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 16'(i), 1'b0, 1'b0);
      total++; if (o_ena !== 1'b1 || o_wea !== 1'b1 || o_addra !== 8'(i - 1) || o_dia !== 16'(i)) begin
        bad++; $display("FAIL basic_wr%0d ena=%b wea=%b addra=%0d dia=%0h exp 1 1 %0d %0h", i, o_ena, o_wea, o_addra, o_dia, i - 1, i);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, 16'h0, 1'b1, 1'b0);
      total++; if (o_enb !== 1'b1 || o_addrb !== 8'(i - 1)) begin bad++; $display("FAIL basic_enb%0d enb=%b addrb=%0d exp 1 %0d", i, o_enb, o_addrb, i - 1); end
      if (i == 1) begin
        total++; if (o_rdv !== 1'b0) begin bad++; $display("FAIL basic_early_rdv got=%b exp=0", o_rdv); end
      end
      total++; if (RD_VALID !== 1'b1 || DOUT !== 16'(i)) begin bad++; $display("FAIL basic_rd%0d rdv=%b dout=%0h exp 1 %0h", i, RD_VALID, DOUT, i); end
    end
    total++; if (EMPTY !== 1'b1 || COUNT !== 9'd0) begin bad++; $display("FAIL basic_empty empty=%b count=%0d exp 1 0", EMPTY, COUNT); end
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    total++; if (RD_VALID !== 1'b0) begin bad++; $display("FAIL basic_rdv_drop got=%b exp=0", RD_VALID); end
  endtask

  task automatic test_fill();
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 256; i++) begin
      tick(1'b1, 16'($urandom), 1'b0, 1'b0);
      total++; if (COUNT !== 9'(i) || AFULL !== (i >= 240) || FULL !== (i == 256) || AEMPTY !== (i <= 16)) begin
        bad++; $display("FAIL fill_%0d count=%0d afull=%b full=%b aempty=%b exp %0d %b %b %b", i, COUNT, AFULL, FULL, AEMPTY, i, i >= 240, i == 256, i <= 16);
      end
    end
    tick(1'b1, 16'h1234, 1'b0, 1'b0);
    total++; if (o_ena !== 1'b0) begin bad++; $display("FAIL ovf_ena got=%b exp=0", o_ena); end
    total++; if (OVERFLOW !== 1'b1 || COUNT !== 9'd256) begin bad++; $display("FAIL ovf_pulse ovf=%b count=%0d exp 1 256", OVERFLOW, COUNT); end
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    total++; if (OVERFLOW !== 1'b0 || FULL !== 1'b1) begin bad++; $display("FAIL ovf_clear ovf=%b full=%b exp 0 1", OVERFLOW, FULL); end
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 16'h5555, 1'b1, 1'b0);
    total++; if (o_ena !== 1'b0 || o_enb !== 1'b1) begin bad++; $display("FAIL simfull_en ena=%b enb=%b exp 0 1", o_ena, o_enb); end
    total++; if (COUNT !== 9'd255 || FULL !== 1'b0 || RD_VALID !== 1'b1 || DOUT !== e_dout) begin
      bad++; $display("FAIL simfull count=%0d full=%b rdv=%b dout=%0h exp 255 0 1 %0h", COUNT, FULL, RD_VALID, DOUT, e_dout);
    end
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    tick(1'b1, 16'h00aa, 1'b1, 1'b0);
    total++; if (o_ena !== 1'b1 || o_enb !== 1'b0) begin bad++; $display("FAIL simempty_en ena=%b enb=%b exp 1 0", o_ena, o_enb); end
    total++; if (COUNT !== 9'd1 || EMPTY !== 1'b0 || UNDERFLOW !== 1'b1) begin bad++; $display("FAIL simempty count=%0d empty=%b unf=%b exp 1 0 1", COUNT, EMPTY, UNDERFLOW); end
    for (int i = 0; i < 99; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0);
    total++; if (COUNT !== 9'd100) begin bad++; $display("FAIL sim100_pre count=%0d exp=100", COUNT); end
    tick(1'b1, 16'h7777, 1'b1, 1'b0);
    total++; if (o_ena !== 1'b1 || o_enb !== 1'b1) begin bad++; $display("FAIL sim100_en ena=%b enb=%b exp 1 1", o_ena, o_enb); end
    total++; if (COUNT !== 9'd100 || RD_VALID !== 1'b1 || DOUT !== 16'h00aa) begin
      bad++; $display("FAIL sim100 count=%0d rdv=%b dout=%0h exp 100 1 aa", COUNT, RD_VALID, DOUT);
    end
  endtask

  task automatic test_wrap_random();
    int          acc_w = 0;
    logic [7:0]  last_a = 8'h0;
    logic        have_last = 1'b0, wrap_seen = 1'b0;
    logic        wr, rd;
    logic [15:0] d;
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    for (int c = 0; c < 4000 && acc_w < 300; c++) begin
      wr = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 2) == 0);
      d  = 16'($urandom);
      tick(wr, d, rd, 1'b0);
      if (e_wacc) begin
        total++; if (o_ena !== 1'b1 || o_addra !== e_addra || o_dia !== d) begin
          bad++; $display("FAIL wrap_wr c=%0d ena=%b addra=%0d dia=%0h exp 1 %0d %0h", c, o_ena, o_addra, o_dia, e_addra, d);
        end
        if (have_last && last_a == 8'hff) begin
          wrap_seen = 1'b1;
          total++; if (o_addra !== 8'h00) begin bad++; $display("FAIL wrap_addra got=%0d exp=0", o_addra); end
        end
        last_a = o_addra; have_last = 1'b1; acc_w++;
      end else begin
        total++; if (o_ena !== 1'b0) begin bad++; $display("FAIL wrap_ena_idle c=%0d got=%b exp=0", c, o_ena); end
      end
      total++; if (o_enb !== e_racc || (e_racc && o_addrb !== e_addrb)) begin
        bad++; $display("FAIL wrap_rd c=%0d enb=%b addrb=%0d exp %b %0d", c, o_enb, o_addrb, e_racc, e_addrb);
      end
      total++; if (COUNT !== 9'(q.size()) || FULL !== (q.size() == 256) || EMPTY !== (q.size() == 0) ||
                   AFULL !== (q.size() >= 240) || AEMPTY !== (q.size() <= 16)) begin
        bad++; $display("FAIL wrap_status c=%0d count=%0d f=%b e=%b af=%b ae=%b exp count=%0d", c, COUNT, FULL, EMPTY, AFULL, AEMPTY, q.size());
      end
      total++; if (RD_VALID !== e_rdv || OVERFLOW !== e_ovf || UNDERFLOW !== e_unf || (e_rdv && DOUT !== e_dout)) begin
        bad++; $display("FAIL wrap_out c=%0d rdv=%b ovf=%b unf=%b dout=%0h exp %b %b %b %0h", c, RD_VALID, OVERFLOW, UNDERFLOW, DOUT, e_rdv, e_ovf, e_unf, e_dout);
      end
    end
    total++; if (acc_w != 300) begin bad++; $display("FAIL wrap_timeout writes=%0d exp=300", acc_w); end
    total++; if (wrap_seen !== 1'b1) begin bad++; $display("FAIL wrap_seen got=%b exp=1", wrap_seen); end
  endtask

  task automatic test_reset_inflight();
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 51; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0);
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    total++; if (COUNT !== 9'd50 || RD_VALID !== 1'b1) begin bad++; $display("FAIL rif_pre count=%0d rdv=%b exp 50 1", COUNT, RD_VALID); end
    tick(1'b1, 16'hdead, 1'b1, 1'b1);
    total++; if (o_rdv !== 1'b0 || o_ena !== 1'b0 || o_enb !== 1'b0 || o_rstb !== 1'b1) begin
      bad++; $display("FAIL rif_during rdv=%b ena=%b enb=%b rstb=%b exp 0 0 0 1", o_rdv, o_ena, o_enb, o_rstb);
    end
    total++; if (COUNT !== 9'd0 || {EMPTY, AEMPTY, FULL, AFULL} !== 4'b1100 || {RD_VALID, OVERFLOW, UNDERFLOW} !== 3'b000 || DOUT !== 16'h0) begin
      bad++; $display("FAIL rif_after count=%0d flags=%b pulses=%b dout=%0h exp 0 1100 000 0", COUNT, {EMPTY, AEMPTY, FULL, AFULL}, {RD_VALID, OVERFLOW, UNDERFLOW}, DOUT);
    end
    tick(1'b1, 16'h4242, 1'b0, 1'b0);
    total++; if (RD_VALID !== 1'b0 || o_addra !== 8'h00) begin bad++; $display("FAIL rif_restart rdv=%b addra=%0d exp 0 0", RD_VALID, o_addra); end
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    total++; if (o_addrb !== 8'h00 || RD_VALID !== 1'b1 || DOUT !== 16'h4242) begin
      bad++; $display("FAIL rif_readback addrb=%0d rdv=%b dout=%0h exp 0 1 4242", o_addrb, RD_VALID, DOUT);
    end
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; DIN = 16'h0;
    test_reset();
    test_underflow();
    test_basic();
    test_fill();
    test_simultaneous();
    test_wrap_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ramb4_fifo_ctrl.md
RAMB4_FIFO_CTRL -- requirements
Module: ramb4_fifo_ctrl

Interface
REQ-001 SHALL have parameter AF_THRESH, default 240, almost-full level: AFULL when COUNT >= AF_THRESH.
REQ-002 SHALL have parameter AE_THRESH, default 16, almost-empty level: AEMPTY when COUNT <= AE_THRESH.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports WR_EN  input  1  write request, and DIN  input  16  write data.
REQ-006 SHALL have ports RD_EN  input  1  read request, DOUT  output  16  read data, and RD_VALID  output  1  DOUT qualifier.
REQ-007 SHALL have ports FULL, EMPTY, AFULL, AEMPTY  output  1 each  status; COUNT  output  9  occupancy 0..256.
REQ-008 SHALL have ports OVERFLOW and UNDERFLOW  output  1 each  one-cycle error pulses.
REQ-009 SHALL drive RAM write port: ENA, WEA  output  1 each; ADDRA  output  8; DIA  output  16.
REQ-010 SHALL drive RAM read port: ENB, RSTB  output  1 each; ADDRB  output  8; WEB  output  1, tied 0; DIB  output  16, tied 0; DOB  input  16.

Function
REQ-011 SHALL accept a write when WR_EN=1 and FULL=0: ENA=WEA=1, ADDRA=wr_ptr, DIA=DIN, same cycle; wr_ptr increments.
REQ-012 SHALL accept a read when RD_EN=1 and EMPTY=0: ENB=1, ADDRB=rd_ptr, same cycle; rd_ptr increments.
REQ-013 SHALL assert RD_VALID exactly one cycle after each accepted read; DOUT=DOB combinationally, with 1-cycle RAM read latency.
REQ-014 SHALL evaluate acceptance against registered flags only; a same-cycle read does not free space for a write at FULL, and a same-cycle write does not enable a read at EMPTY.
REQ-015 SHALL leave COUNT unchanged when read and write are both accepted; otherwise +1 on write-only and -1 on read-only.
REQ-016 SHALL wrap 8-bit pointers 255->0 with no special handling.
REQ-017 SHALL implement occupancy FSM states S_EMPTY, S_PART, S_FULL:
- S_EMPTY->S_PART on write.
- S_PART->S_EMPTY on read-only at COUNT=1.
- S_PART->S_FULL on write-only at COUNT=255.
- S_FULL->S_PART on read.
- All other cases hold state.
REQ-018 SHALL derive EMPTY=(state==S_EMPTY) and FULL=(state==S_FULL), both registered.
REQ-019 SHALL register AFULL and AEMPTY from next COUNT so they update in the same cycle as COUNT.
REQ-020 SHALL pulse OVERFLOW for one cycle after WR_EN=1 while FULL=1, and UNDERFLOW for one cycle after RD_EN=1 while EMPTY=1; rejected requests change no state.
REQ-021 SHALL never present ADDRA==ADDRB with ENA and ENB both high; this holds by construction of REQ-014 and is checked by assertion.

Reset
REQ-022 SHALL, on RST=1 at a clock edge, clear: pointers to 0, COUNT=0, state=S_EMPTY, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, RD_VALID=0, OVERFLOW=0, UNDERFLOW=0.
REQ-023 SHALL hold ENA=WEA=ENB=0 and RSTB=1 while RST=1, so DOB reads 0.
REQ-024 SHALL drop a read accepted in the cycle before RST: RD_VALID=0 in the RST cycle; RAM contents are not cleared.

Structure
REQ-025 SHALL place DEPTH=256, AW=8, DW=16, CW=9 and the occupancy state enum in package ramb4_fifo_pkg.
REQ-026 SHALL isolate pointer, COUNT and FSM logic in sub-module ramb4_fifo_ptr; the RAM instance stays outside this block.

Verification
REQ-027 SHALL cover write 0x0001..0x0003 then read 3 -> DOUT 0x0001, 0x0002, 0x0003, each with RD_VALID one cycle after RD_EN; EMPTY=1 after the last read.
REQ-028 SHALL cover 256 writes -> FULL=1, COUNT=256, AFULL=1 from COUNT=240; a 257th write -> OVERFLOW pulse, COUNT stays 256.
REQ-029 SHALL cover RD_EN at reset -> UNDERFLOW pulse, RD_VALID=0, ENB=0.
REQ-030 SHALL cover simultaneous WR_EN+RD_EN:
- at FULL: read only, COUNT=255.
- at EMPTY: write only, COUNT=1.
- at COUNT=100: COUNT stays 100.
REQ-031 SHALL cover 300 writes interleaved with reads, crossing pointer wrap -> data order preserved, ADDRA 255 followed by 0.
REQ-032 SHALL cover RST asserted at COUNT=50 with a read in flight -> all outputs at reset values next cycle, no RD_VALID.
